// File: rtl/iob_wb_bridge.sv
// IOb-native slave to Wishbone classic master bridge with retry and error responses.
// Optional bus watchdog: define IOB_WB_BRIDGE_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit.
module iob_wb_bridge #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid,
  input  logic [ADDR_W-1:0]                    address,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [DATA_W/8-1:0]                  wstrb,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 ready,
  output logic                                 err_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]                    wb_dat_o,
  output logic [DATA_W/8-1:0]                  wb_sel_o,
  output logic                                 wb_we_o,
  output logic                                 wb_cyc_o,
  output logic                                 wb_stb_o,
  input  logic [DATA_W-1:0]                    wb_dat_i,
  input  logic                                 wb_ack_i,
  input  logic                                 wb_err_i,
  input  logic                                 wb_rty_i
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_W / 8);
  localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBus, StGap, StResp} state_e;

  state_e           state;
  logic [RTY_W-1:0] rty_cnt;
  logic             retry_ok;
  logic             to_hit;

  assign retry_ok = (32'(rty_cnt) < MAX_RETRY);

  // Byte-offset bits never reach the word-addressed Wishbone side.
  if (ADDR_LSB > 0) begin : g_addr_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^address[ADDR_LSB-1:0];
  end

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Counter is held at zero outside BUS, so every BUS entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != StBus) begin
      to_cnt <= '0;
    end else if (!(wb_ack_i || wb_err_i || wb_rty_i)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (state == StBus) && !(wb_ack_i || wb_err_i || wb_rty_i) &&
                  (32'(to_cnt) == TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      rty_cnt  <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err_o    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (valid) begin
            wb_adr_o <= address[ADDR_W-1:ADDR_LSB];
            wb_dat_o <= wdata;
            wb_we_o  <= |wstrb;
            wb_sel_o <= (|wstrb) ? wstrb : '1;
            rty_cnt  <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= StBus;
          end
        end
        StBus: begin
          // Priority ack > err > rty; any response beats the watchdog.
          if (wb_ack_i) begin
            rdata    <= wb_we_o ? '0 : wb_dat_i;
            err_o    <= 1'b0;
            ready    <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= StResp;
          end else if (wb_err_i || (wb_rty_i && !retry_ok) || to_hit) begin
            rdata    <= '0;
            err_o    <= 1'b1;
            ready    <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= StResp;
          end else if (wb_rty_i) begin
            rty_cnt  <= rty_cnt + RTY_W'(1);
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= StGap;
          end
        end
        StGap: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= StBus;
        end
        StResp: begin
          ready <= 1'b0;
          err_o <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_wb_bridge.sv
// Directed self-checking bench for iob_wb_bridge; the bench acts as IOb master and Wishbone slave.
module tb_iob_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err_o;
  logic [13:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_wb_bridge #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .MAX_RETRY      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .address  (address),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .err_o    (err_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One IOb transaction. Each BUS phase waits 'waits' cycles, the first n_rty phases answer
  // rty, later phases answer with fin = {rty, err, ack}. exp_lat counts cycles after sampling.
  task automatic xact(input string tag, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input int waits, input int n_rty,
                      input logic [2:0] fin, input logic [31:0] sdat, input int exp_lat,
                      input int exp_phases, input logic [31:0] exp_rd, input logic exp_err);
    int   lat;
    int   phases;
    int   wc;
    logic prev_cyc;
    logic done;
    valid   = 1'b1;
    address = addr;
    wdata   = wd;
    wstrb   = ws;
    tick();
    // Request is captured; scramble inputs to show they are ignored.
    address  = 16'hFFFF;
    wdata    = 32'h0;
    wstrb    = 4'hF;
    lat      = 1;
    phases   = 0;
    wc       = 0;
    prev_cyc = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (ready) begin
        done = 1'b1;
      end else begin
        if (wb_cyc_o && !prev_cyc) begin
          phases++;
          wc = 0;
          if (phases == 1) begin
            check({tag, ".adr"}, wb_adr_o, addr[15:2]);
            check({tag, ".sel"}, wb_sel_o, (ws != 0) ? ws : 4'hF);
            check({tag, ".we"}, wb_we_o, ws != 0);
            check({tag, ".stb"}, wb_stb_o, 1'b1);
            if (ws != 0) check({tag, ".dat"}, wb_dat_o, wd);
          end
        end
        {wb_rty_i, wb_err_i, wb_ack_i} = 3'b000;
        wb_dat_i = '0;
        if (wb_cyc_o) begin
          if (wc < waits) begin
            wc++;
          end else if (phases <= n_rty) begin
            wb_rty_i = 1'b1;
          end else begin
            {wb_rty_i, wb_err_i, wb_ack_i} = fin;
            wb_dat_i = sdat;
          end
        end
        prev_cyc = wb_cyc_o;
        tick();
        lat++;
      end
    end
    {wb_rty_i, wb_err_i, wb_ack_i} = 3'b000;
    check({tag, ".ready_seen"}, done, 1'b1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".phases"}, phases, exp_phases);
    check({tag, ".rdata"}, rdata, exp_rd);
    check({tag, ".err"}, err_o, exp_err);
    check({tag, ".cyc_resp"}, wb_cyc_o, 1'b0);
    valid = 1'b0;
    tick();
    check({tag, ".ready_drop"}, ready, 1'b0);
    check({tag, ".err_drop"}, err_o, 1'b0);
    check({tag, ".rdata_hold"}, rdata, exp_rd);
  endtask

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
  localparam int StuckCycles = 4;
`else
  localparam int StuckCycles = 120;
`endif

  initial begin
    int cnt;
    #2;
    check("rst.cyc", wb_cyc_o, 1'b0);
    check("rst.stb", wb_stb_o, 1'b0);
    check("rst.ready", ready, 1'b0);
    check("rst.err", err_o, 1'b0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.adr", wb_adr_o, 14'h0);
    #6 rst = 1'b0;
    tick();

    xact("rd0", 16'h0010, 32'h0, 4'h0, 0, 0, 3'b001, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 1'b0);
    xact("wr3", 16'h0024, 32'h12345678, 4'h3, 3, 0, 3'b001, 32'hCAFEF00D, 5, 1, 32'h0, 1'b0);
    xact("rty2", 16'h0040, 32'h0, 4'h0, 0, 2, 3'b001, 32'hA5A5A5A5, 6, 3, 32'hA5A5A5A5, 1'b0);
    xact("rtyx", 16'h0044, 32'h0, 4'h0, 0, 99, 3'b001, 32'h0, 8, 4, 32'h0, 1'b1);
    xact("all3", 16'h0030, 32'h0, 4'h0, 0, 0, 3'b111, 32'h0BADF00D, 2, 1, 32'h0BADF00D, 1'b0);
    xact("werr", 16'h0008, 32'h000000FF, 4'hF, 1, 0, 3'b010, 32'h12345678, 3, 1, 32'h0, 1'b1);
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
    xact("tmo", 16'h0050, 32'h0, 4'h0, 1000, 0, 3'b001, 32'h0, 9, 1, 32'h0, 1'b1);
`endif

    // Silent slave: cyc must hold, then an asynchronous reset aborts the cycle.
    valid   = 1'b1;
    address = 16'h0060;
    wstrb   = 4'h0;
    tick();
    cnt = 0;
    for (int i = 0; i < StuckCycles; i++) begin
      if (wb_cyc_o) cnt++;
      tick();
    end
    check("stuck.cyc_cycles", cnt, StuckCycles);
    check("stuck.ready", ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.cyc", wb_cyc_o, 1'b0);
    check("arst.stb", wb_stb_o, 1'b0);
    check("arst.ready", ready, 1'b0);
    check("arst.err", err_o, 1'b0);
    valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    check("post.idle_cyc", wb_cyc_o, 1'b0);
    xact("post", 16'h0010, 32'h0, 4'h0, 0, 0, 3'b001, 32'h13579BDF, 2, 1, 32'h13579BDF, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
